// File: rtl/gate_test_driver.sv
// Bring-up driver for the two-input basic-gate unit: sweeps a/b, checks the nine outputs,
// and reports pass, a saturating error count and a sticky fail mask. Optional: GATE_TEST_FIRST_FAIL_EN.
module gate_test_driver #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 a_o,
    output logic                 b_o,
    input  logic [8:0]           gate_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [8:0]           fail_mask,
`ifdef GATE_TEST_FIRST_FAIL_EN
    output logic                 first_fail_vld,
    output logic [1:0]           first_fail_idx,
    output logic [8:0]           first_fail_obs,
`endif
    output logic [1:0]           vec_idx
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [LW-1:0] LOOP_LAST   = LW'(LOOPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] settle_cnt;
    logic [LW-1:0] loop_cnt;
    logic [8:0]    expected;
    logic [8:0]    mismatch;
    logic          last_vec;

    // Bit order matches gate_in: and, or, not_a, nand, nor, xor, xnor, buf_a, buf_b.
    assign expected = {b_o, a_o, ~(a_o ^ b_o), a_o ^ b_o, ~(a_o | b_o),
                       ~(a_o & b_o), ~a_o, a_o | b_o, a_o & b_o};
    assign mismatch = gate_in ^ expected;
    assign last_vec = (vec_idx == 2'd3) && (loop_cnt == LOOP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_DRIVE;
            S_DRIVE:  state_nxt = (SETTLE_CYCLES > 0) ? S_SETTLE : S_CHECK;
            S_SETTLE: if (settle_cnt == '0) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = last_vec ? S_DONE : S_DRIVE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_o            <= 1'b0;
            b_o            <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            fail_mask      <= '0;
            vec_idx        <= '0;
            loop_cnt       <= '0;
            settle_cnt     <= '0;
`ifdef GATE_TEST_FIRST_FAIL_EN
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
            first_fail_obs <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_cnt        <= '0;
                        fail_mask      <= '0;
                        pass           <= 1'b0;
                        vec_idx        <= '0;
                        loop_cnt       <= '0;
`ifdef GATE_TEST_FIRST_FAIL_EN
                        first_fail_vld <= 1'b0;
                        first_fail_idx <= '0;
                        first_fail_obs <= '0;
`endif
                    end
                end
                S_DRIVE: begin
                    a_o        <= vec_idx[1];
                    b_o        <= vec_idx[0];
                    busy       <= 1'b1;
                    settle_cnt <= SETTLE_LOAD;
                end
                S_SETTLE: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                end
                S_CHECK: begin
                    fail_mask <= fail_mask | mismatch;
                    if ((mismatch != '0) && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
`ifdef GATE_TEST_FIRST_FAIL_EN
                    if ((mismatch != '0) && !first_fail_vld) begin
                        first_fail_vld <= 1'b1;
                        first_fail_idx <= vec_idx;
                        first_fail_obs <= gate_in;
                    end
`endif
                    if (!last_vec) begin
                        vec_idx <= vec_idx + 1'b1;
                        if (vec_idx == 2'd3) loop_cnt <= loop_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    pass <= (err_cnt == '0);
                end
                default: ;
            endcase
        end
    end

endmodule
